// File: rtl/snn_uart_ctrl.sv
// Host-link sequencer: unpacks received image bytes into the 1-bit input RAM,
// kicks the SNN core and returns the classified digit over UART TX.
module snn_uart_ctrl #(
    parameter int NUM_BITS   = 784,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wdata,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [3:0]            core_digit,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_rdy,
    output logic [7:0]            led,
    output logic                  busy
);

    localparam int BC_W = ADDR_WIDTH - 3;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NUM_BITS / 8 - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_UNPACK,
        S_START,
        S_WAIT_CORE,
        S_SEND
    } state_t;

    state_t                state_q, state_d;
    logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic                  buf_full_q, buf_full_d;
    logic [7:0]            buf_q, buf_d;
    logic [7:0]            shift_q, shift_d;
    logic                  overrun_q, overrun_d;
    logic [3:0]            digit_q, digit_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_wdata_q, ram_wdata_d;
    logic                  core_start_q, core_start_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;
    logic                  pop;
    logic                  capture;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        digit_d      = digit_q;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = 1'b0;
        core_start_d = 1'b0;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        pop          = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (buf_full_q) begin
                    pop       = 1'b1;
                    shift_d   = buf_q;
                    bit_cnt_d = 3'd0;
                    state_d   = S_UNPACK;
                end
            end
            S_UNPACK: begin
                // The {byte, bit} concatenation is 8*byte_cnt+i without an adder.
                ram_we_d    = 1'b1;
                ram_addr_d  = {byte_cnt_q, bit_cnt_q};
                ram_wdata_d = shift_q[bit_cnt_q];
                bit_cnt_d   = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    state_d    = (byte_cnt_q == LAST_BYTE) ? S_START : S_LOAD;
                end
            end
            S_START: begin
                core_start_d = 1'b1;
                byte_cnt_d   = '0;
                state_d      = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                if (core_done) begin
                    tx_data_d = {4'h0, core_digit};
                    digit_d   = core_digit;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_rdy) begin
                    tx_start_d = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase

        // A byte arriving on the same cycle the buffer drains is still kept.
        capture    = rx_rdy && (state_q == S_LOAD || state_q == S_UNPACK)
                     && (!buf_full_q || pop);
        buf_d      = capture ? rx_data : buf_q;
        buf_full_d = capture ? 1'b1 : (pop ? 1'b0 : buf_full_q);
        overrun_d  = overrun_q || (rx_rdy && !capture);
        busy_d     = !(state_d == S_LOAD && byte_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOAD;
            byte_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            buf_full_q   <= 1'b0;
            overrun_q    <= 1'b0;
            digit_q      <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 1'b0;
            core_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            buf_full_q   <= buf_full_d;
            overrun_q    <= overrun_d;
            digit_q      <= digit_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            core_start_q <= core_start_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q   <= buf_d;
        shift_q <= shift_d;
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign core_start = core_start_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign led        = {overrun_q, 3'b000, digit_q};
    assign busy       = busy_q;

endmodule

// File: tb/tb_snn_uart_ctrl.sv
// Directed bench for snn_uart_ctrl: RAM writes and TX bytes are checked
// against scoreboard queues filled as stimulus is driven.
module tb_snn_uart_ctrl;

    localparam int NB = 784;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_rdy = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic          ram_wdata;
    logic          core_start;
    logic          core_done = 1'b0;
    logic [3:0]    core_digit = '0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_rdy = 1'b1;
    logic [7:0]    led;
    logic          busy;

    snn_uart_ctrl #(.NUM_BITS(NB), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
        .tx_start(tx_start), .tx_data(tx_data), .tx_rdy(tx_rdy),
        .led(led), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          bitv;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];
    logic       ram_m [0:1023];
    int n_checks = 0;
    int n_pass   = 0;
    int we_cnt   = 0;
    int cs_cnt   = 0;
    int tx_cnt   = 0;
    int exp_idx  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitor: sampled on the falling edge, away from input changes.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we === 1'b1) begin
                we_cnt++;
                ram_m[ram_addr] = ram_wdata;
                if (exp_wr.size() == 0) begin
                    check("ram_we_unexpected", 32'(ram_addr), 32'hFFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("ram_addr", 32'(ram_addr), 32'(e.addr));
                    check("ram_wdata", 32'(ram_wdata), 32'(e.bitv));
                end
            end
            if (core_start === 1'b1) cs_cnt++;
            if (tx_start === 1'b1) begin
                tx_cnt++;
                check("tx_rdy_at_start", 32'(tx_rdy), 32'd1);
                if (exp_tx.size() == 0) check("tx_unexpected", 32'(tx_data), 32'hFFFF);
                else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; rx_rdy is sampled by the next edge.
    task automatic pulse_rx(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(posedge clk);
        #1;
        rx_rdy  = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            wr_t e;
            e.addr = AW'(8 * exp_idx + i);
            e.bitv = b[i];
            exp_wr.push_back(e);
        end
        exp_idx++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        push_byte(b);
        pulse_rx(b);
        if (gap > 0) cycles(gap);
    endtask

    task automatic wait_core_start(input int max_cyc, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                lat = i;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // core_done is taken by the next edge; tx_start should show two edges later.
    task automatic finish_image(input logic [3:0] d, input string tag);
        exp_tx.push_back({4'h0, d});
        core_digit = d;
        core_done  = 1'b1;
        @(posedge clk);
        #1;
        core_done  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check(tag, 32'(tx_start), 32'd1);
        cycles(1);
    endtask

    initial begin
        int lat;
        int cs0;
        int tx0;
        logic [7:0] b;
        logic [7:0] pat;

        cycles(3);
        @(negedge clk);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_core_start", 32'(core_start), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_led", 32'(led), 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(2);

        // Full image of 0xA5, digit 6.
        exp_idx = 0;
        we_cnt  = 0;
        send_byte(8'hA5, 11);
        check("busy_mid_image", 32'(busy), 1);
        for (int k = 1; k < 97; k++) send_byte(8'hA5, 11);
        send_byte(8'hA5, 0);
        wait_core_start(20, lat);
        check("t1_start_latency_ok", 32'(lat > 0 && lat <= 11), 1);
        check("t1_core_start_cnt", 32'(cs_cnt), 1);
        check("t1_we_cnt", 32'(we_cnt), 784);
        pat = 8'hA5;
        for (int k = 0; k < 98; k += 48)
            for (int i = 0; i < 8; i++)
                check("t1_ram_bit", 32'(ram_m[8 * k + i]), 32'(pat[i]));
        finish_image(4'd6, "t1_tx_latency");
        check("t1_tx_cnt", 32'(tx_cnt), 1);
        check("t1_led", 32'(led), 32'h06);
        check("t1_busy_idle", 32'(busy), 0);

        // Stray core_done while loading is ignored.
        tx0 = tx_cnt;
        core_digit = 4'd9;
        core_done  = 1'b1;
        cycles(1);
        core_done  = 1'b0;
        cycles(6);
        check("t6_no_tx", 32'(tx_cnt), 32'(tx0));
        check("t6_led", 32'(led), 32'h06);
        check("t6_busy", 32'(busy), 0);

        // Bit order / mapping, then a stalled transmitter.
        for (int a = 0; a < 16; a++) ram_m[a] = 1'bx;
        exp_idx = 0;
        send_byte(8'h01, 11);
        send_byte(8'h80, 11);
        for (int k = 2; k < 97; k++) send_byte(8'h00, 11);
        send_byte(8'h00, 0);
        wait_core_start(20, lat);
        check("t2_start_seen", 32'(lat > 0), 1);
        check("t2_ram0", 32'(ram_m[0]), 1);
        for (int a = 1; a < 15; a++) check("t2_ram_zero", 32'(ram_m[a]), 0);
        check("t2_ram15", 32'(ram_m[15]), 1);
        cs0 = cs_cnt;
        tx0 = tx_cnt;
        tx_rdy = 1'b0;
        exp_tx.push_back(8'h03);
        core_digit = 4'd3;
        core_done  = 1'b1;
        cycles(1);
        core_done  = 1'b0;
        cycles(50);
        check("t4_tx_held", 32'(tx_cnt), 32'(tx0));
        check("t4_led", 32'(led), 32'h03);
        tx_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_tx_after_rdy", 32'(tx_start), 1);
        cycles(3);
        check("t4_tx_once", 32'(tx_cnt), 32'(tx0 + 1));
        check("t4_no_restart", 32'(cs_cnt), 32'(cs0));

        // Two bytes 1 cycle apart during UNPACK with the buffer full.
        exp_idx = 0;
        push_byte(8'h3C);
        pulse_rx(8'h3C);
        cycles(1);
        push_byte(8'hC3);
        pulse_rx(8'hC3);
        cycles(1);
        pulse_rx(8'hFF);
        cycles(25);
        check("t3_overrun", 32'(led[7]), 1);
        check("t3_two_bytes", 32'(exp_wr.size()), 0);
        cs0 = cs_cnt;
        for (int k = 2; k < 97; k++) send_byte(8'h5A, 11);
        check("t3_no_early_start", 32'(cs_cnt), 32'(cs0));
        send_byte(8'h5A, 0);
        wait_core_start(20, lat);
        check("t3_start_seen", 32'(lat > 0), 1);
        finish_image(4'd1, "t3_tx");
        check("t3_led", 32'(led), 32'h81);

        // Reset mid-image, then a complete random image.
        exp_idx = 0;
        for (int k = 0; k < 40; k++) send_byte(8'($urandom_range(0, 255)), 11);
        check("t5_partial_drained", 32'(exp_wr.size()), 0);
        rst = 1'b1;
        cycles(2);
        @(negedge clk);
        check("t5_rst_led", 32'(led), 0);
        check("t5_rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(2);
        cs0 = cs_cnt;
        exp_idx = 0;
        for (int k = 0; k < 97; k++) send_byte(8'($urandom_range(0, 255)), 11);
        check("t5_no_early_start", 32'(cs_cnt), 32'(cs0));
        b = 8'($urandom_range(0, 255));
        send_byte(b, 0);
        wait_core_start(20, lat);
        check("t5_start_seen", 32'(lat > 0), 1);
        check("t5_one_start", 32'(cs_cnt), 32'(cs0 + 1));
        finish_image(4'd9, "t5_tx");
        check("t5_led", 32'(led), 32'h09);

        cycles(5);
        check("end_wr_queue", 32'(exp_wr.size()), 0);
        check("end_tx_queue", 32'(exp_tx.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
